// File: rtl/poly_mod_addsub_stream.sv
// poly_mod_addsub_stream
//   Streaming modular add/subtract engine for ML-KEM coefficients (q = 3329).
//   One (a,b) pair per accepted beat, one registered result per beat, framed
//   as exactly N_COEFFS beats per start_i.
//
//   Handshake rule (both sides): a beat transfers on a rising edge where
//   valid && ready are both high. A producer holding valid high keeps its data
//   stable until that edge. in_ready_o depends on out_ready_i combinationally,
//   so the engine can take a new pair in the same cycle it hands one off and
//   sustain one beat per clock.
//
//   state_o exposes the FSM state (IDLE=0, RUN=1, DONE=2) for debug/checkers.
module poly_mod_addsub_stream #(
  parameter int N_COEFFS = 256,
  parameter int Q        = 3329,
  parameter int WIDTH    = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_last_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [1:0]       state_o
);

  // Counters must be able to hold N_COEFFS itself (in_cnt saturates there).
  localparam int CW = $clog2(N_COEFFS + 1);
  localparam logic [CW-1:0]  N_FULL = CW'(N_COEFFS);
  localparam logic [CW-1:0]  N_LAST = CW'(N_COEFFS - 1);
  localparam logic [WIDTH:0] Q_EXT  = (WIDTH + 1)'(Q);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    in_cnt;
  logic [CW-1:0]    out_cnt;
  logic             sub_q;

  logic             accept;
  logic             out_hs;
  logic             op_bad;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [WIDTH:0]   res_w;

  assign accept = in_valid_i && in_ready_o;
  assign out_hs = out_valid_o && out_ready_i;
  assign op_bad = ({1'b0, a_i} >= Q_EXT) || ({1'b0, b_i} >= Q_EXT);

  assign in_ready_o = (state == S_RUN) && (in_cnt < N_FULL) &&
                      (!out_valid_o || out_ready_i);
  assign out_last_o = out_valid_o && (out_cnt == N_LAST);
  assign busy_o     = (state == S_RUN);
  assign done_o     = (state == S_DONE);
  assign state_o    = state;

  // Single conditional correction: add folds [Q,2Q-2] down, sub folds
  // negative differences (MSB of the WIDTH+1 bit difference) up by Q.
  always_comb begin
    sum_w  = {1'b0, a_i} + {1'b0, b_i};
    diff_w = {1'b0, a_i} - {1'b0, b_i};
    res_w  = '0;
    if (sub_q) begin
      res_w = diff_w[WIDTH] ? (diff_w + Q_EXT) : diff_w;
    end else begin
      res_w = (sum_w >= Q_EXT) ? (sum_w - Q_EXT) : sum_w;
    end
  end

  // Frame FSM, beat counters, output register and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      in_cnt      <= '0;
      out_cnt     <= '0;
      sub_q       <= 1'b0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      err_o       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            sub_q   <= sub_i;
            in_cnt  <= '0;
            out_cnt <= '0;
            err_o   <= 1'b0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (accept) begin
            out_data_o  <= res_w[WIDTH-1:0];
            out_valid_o <= 1'b1;
            in_cnt      <= in_cnt + CW'(1);
            if (op_bad) begin
              err_o <= 1'b1;
            end
          end else if (out_hs) begin
            out_valid_o <= 1'b0;
          end
          if (out_hs) begin
            out_cnt <= out_cnt + CW'(1);
            if (out_cnt == N_LAST) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_poly_mod_addsub_stream.sv
// tb_poly_mod_addsub_stream
//   Randomized frames against a plain-arithmetic reference model. A driver
//   feeds pairs and pushes expected results; a negedge monitor pops them on
//   every output handshake and checks hold, latency, last and done timing.
module tb_poly_mod_addsub_stream;

  localparam int N = 256;
  localparam int Q = 3329;
  localparam int W = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start_i = 1'b0;
  logic         sub_i = 1'b0;
  logic         in_valid_i = 1'b0;
  logic         in_ready_o;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         out_valid_o;
  logic         out_ready_i = 1'b1;
  logic [W-1:0] out_data_o;
  logic         out_last_o;
  logic         busy_o;
  logic         done_o;
  logic         err_o;
  logic [1:0]   state_o;

  poly_mod_addsub_stream #(.N_COEFFS(N), .Q(Q), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .sub_i(sub_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .a_i(a_i), .b_i(b_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_last_o(out_last_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .state_o(state_o)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // In-range operands: true modular arithmetic. Out-of-range operands: one
  // conditional correction then truncation to W bits.
  function automatic logic [W-1:0] ref_result(input bit sub, input int a, input int b);
    int r;
    if (a < Q && b < Q) begin
      r = sub ? (((a - b) % Q) + Q) % Q : (a + b) % Q;
    end else if (sub) begin
      r = a - b;
      if (r < 0) r = r + Q;
    end else begin
      r = a + b;
      if (r >= Q) r = r - Q;
    end
    return W'(r & ((1 << W) - 1));
  endfunction

  function automatic int rand_coef();
    case ($urandom_range(0, 7))
      0:       return 0;
      1:       return Q - 1;
      default: return int'($urandom_range(0, Q - 1));
    endcase
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [W-1:0] exp_q[$];
  int           beat_cnt = 0;
  bit           prev_acc = 0;
  bit           prev_stall = 0;
  bit           prev_last_hs = 0;
  logic [W-1:0] prev_data = '0;
  logic         prev_last = 1'b0;

  // Sampled on the falling edge, half a cycle away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      beat_cnt     = 0;
      prev_acc     = 0;
      prev_stall   = 0;
      prev_last_hs = 0;
    end else begin
      logic [W-1:0] e;
      if (prev_acc) check("latency_valid", 32'(out_valid_o), 32'd1);
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid_o), 32'd1);
        check("hold_data", 32'(out_data_o), 32'(prev_data));
        check("hold_last", 32'(out_last_o), 32'(prev_last));
      end
      if (out_valid_o && !out_ready_i) check("stall_in_ready", 32'(in_ready_o), 32'd0);
      check("done_timing", 32'(done_o), 32'(prev_last_hs));
      prev_last_hs = 0;
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("data", 32'(out_data_o), 32'(e));
          check("last", 32'(out_last_o), 32'(beat_cnt == N - 1));
          prev_last_hs = (beat_cnt == N - 1);
          beat_cnt = (beat_cnt == N - 1) ? 0 : beat_cnt + 1;
        end
      end
      prev_acc   = in_valid_i && in_ready_o;
      prev_stall = out_valid_o && !out_ready_i;
      prev_data  = out_data_o;
      prev_last  = out_last_o;
    end
  end

  // ---------------- downstream backpressure ----------------
  bit bp_en = 0;
  always @(posedge clk) begin
    #1 out_ready_i = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- driver ----------------
  int a_arr[N];
  int b_arr[N];

  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      a_arr[i] = rand_coef();
      b_arr[i] = rand_coef();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid_o), 32'd0);
    check({tag, "_out_data"}, 32'(out_data_o), 32'd0);
    check({tag, "_out_last"}, 32'(out_last_o), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready_o), 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_done"}, 32'(done_o), 32'd0);
    check({tag, "_err"}, 32'(err_o), 32'd0);
  endtask

  // Runs one frame. abort_at >= 0 pulls rst_n low before that beat.
  // bad_idx >= 0 marks the beat carrying an out-of-range operand.
  task automatic run_frame(input bit sub, input bit gaps, input bit full_rate,
                           input bit mid_start, input int bad_idx, input int abort_at);
    int  waits_total;
    int  waited;
    bit  acc;
    waits_total = 0;
    @(posedge clk); #1;
    start_i = 1'b1;
    sub_i   = sub;
    @(posedge clk); #1;
    start_i = 1'b0;
    sub_i   = 1'($urandom_range(0, 1));   // mode is latched; later changes are irrelevant
    check("start_busy", 32'(busy_o), 32'd1);
    check("start_err_clear", 32'(err_o), 32'd0);
    for (int i = 0; i < N; i++) begin
      if (i == abort_at) begin
        #1 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        in_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        check("after_rst_state", 32'(state_o), 32'd0);
        return;
      end
      while (gaps && $urandom_range(0, 3) == 0) begin
        in_valid_i = 1'b0;
        a_i = W'($urandom_range(0, 4095));
        b_i = W'($urandom_range(0, 4095));
        @(posedge clk); #1;
      end
      if (i == bad_idx) check("err_before_bad", 32'(err_o), 32'd0);
      exp_q.push_back(ref_result(sub, a_arr[i], b_arr[i]));
      in_valid_i = 1'b1;
      a_i = W'(a_arr[i]);
      b_i = W'(b_arr[i]);
      if (mid_start && i == 50) start_i = 1'b1;
      acc = 0;
      waited = 0;
      while (!acc && waited < 1000) begin
        @(negedge clk);
        acc = in_ready_o;
        @(posedge clk); #1;
        start_i = 1'b0;
        waited++;
      end
      waits_total += waited;
      check("in_accept", 32'(acc), 32'd1);
      if (i == bad_idx) check("err_set", 32'(err_o), 32'd1);
      if (mid_start && i == 50) check("mid_start_busy", 32'(busy_o), 32'd1);
    end
    in_valid_i = 1'b0;
    if (full_rate) check("full_rate_cycles", 32'(waits_total), 32'(N));
    waited = 0;
    @(negedge clk);
    while (!done_o && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("done_seen", 32'(done_o), 32'd1);
    check("frame_drained", 32'(exp_q.size()), 32'd0);
    check("done_err_sticky", 32'(err_o), 32'(bad_idx >= 0));
    @(posedge clk); #1;
    check("back_to_idle", 32'(state_o), 32'd0);
    check("idle_busy", 32'(busy_o), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #2 check_all_zero("reset_hold");
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("reset_release");
    check("reset_state", 32'(state_o), 32'd0);

    // Directed add values at the head of a full-rate frame.
    fill_random();
    a_arr[0] = 3000; b_arr[0] = 400;
    a_arr[1] = 3328; b_arr[1] = 1;
    a_arr[2] = 0;    b_arr[2] = 0;
    bp_en = 0;
    run_frame(1'b0, 1'b0, 1'b1, 1'b0, -1, -1);

    // Directed sub values, with input gaps and output backpressure.
    fill_random();
    a_arr[0] = 20;  b_arr[0] = 50;
    a_arr[1] = 0;   b_arr[1] = 1;
    a_arr[2] = 0;   b_arr[2] = 3328;
    a_arr[3] = 100; b_arr[3] = 100;
    bp_en = 1;
    run_frame(1'b1, 1'b1, 1'b0, 1'b0, -1, -1);

    // Backpressure, start_i pulsed mid-frame, out-of-range operand a=3329.
    fill_random();
    a_arr[20] = 3329; b_arr[20] = 5;
    run_frame(1'b0, 1'b1, 1'b0, 1'b1, 20, -1);

    // Sub frame abandoned by reset at beat 100.
    fill_random();
    run_frame(1'b1, 1'b0, 1'b0, 1'b0, -1, 100);

    // Clean frame after reset, full rate; start clears the earlier error.
    fill_random();
    bp_en = 0;
    run_frame(1'b1, 1'b0, 1'b1, 1'b0, -1, -1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
